if_id_stage: RTL and testbench

- IF/ID pipeline stage directly downstream of the PC + IMEM fetch stage.
- Buffers each fetched {pc, instruction} pair in a small FIFO using a valid/ready handshake.
- Presents the head entry to the decode side, split into MIPS fields (R-type and I-type views), with a sign-extended immediate.
- Absorbs downstream stalls and supports a synchronous flush for taken branches/jumps.

---
 rtl/if_id_stage.sv | 137 +++++++++++++
 tb/tb_if_id_stage.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/if_id_stage.sv
// IF/ID stage: buffers fetched {pc, instr} pairs in a DEPTH-entry FIFO and decodes MIPS fields of the head.
// Latency: 1 cycle. An entry pushed at edge N is visible on out_* after edge N; there is no bypass.
// Backpressure: in_ready drops when count == DEPTH and never looks at out_ready. Flush empties the buffer at the next edge.
// Optional build macro IF_ID_PERF_CNT_EN adds the stall_cycles and flush_count counters.
module if_id_stage #(
  parameter int DEPTH   = 2,
  parameter int PC_W    = 32,
  parameter int INSTR_W = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [PC_W-1:0]    in_pc,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [PC_W-1:0]    out_pc,
  output logic [INSTR_W-1:0] out_instr,
  output logic [5:0]         opcode,
  output logic [4:0]         rs,
  output logic [4:0]         rt,
  output logic [4:0]         rd,
  output logic [4:0]         shamt,
  output logic [5:0]         funct,
  output logic [31:0]        imm_sext,
  output logic               is_rtype
`ifdef IF_ID_PERF_CNT_EN
  ,
  output logic [31:0]        stall_cycles,
  output logic [31:0]        flush_count
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } entry_t;

  entry_t         mem_q [DEPTH];
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  count_q, count_d;
  logic           push, pop;
  entry_t         head;

  assign in_ready  = (count_q < FULL_CNT);
  assign out_valid = (count_q != '0);
  assign push      = in_valid & in_ready & ~flush;
  assign pop       = out_valid & out_ready & ~flush;

  // Next-state for pointers and occupancy; flush overrides everything.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state registers with asynchronous clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; stale slots are never visible because outputs are masked when empty.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= '{pc: in_pc, instr: in_instr};
  end

  assign head = mem_q[rd_ptr_q];

  // Head presentation and field decode, forced to zero while the buffer is empty.
  always_comb begin
    out_pc    = '0;
    out_instr = '0;
    if (out_valid) begin
      out_pc    = head.pc;
      out_instr = head.instr;
    end
  end

  assign opcode   = out_instr[31:26];
  assign rs       = out_instr[25:21];
  assign rt       = out_instr[20:16];
  assign rd       = out_instr[15:11];
  assign shamt    = out_instr[10:6];
  assign funct    = out_instr[5:0];
  assign imm_sext = {{16{out_instr[15]}}, out_instr[15:0]};
  assign is_rtype = out_valid & (out_instr[31:26] == 6'b000000);

`ifdef IF_ID_PERF_CNT_EN
  logic [31:0] stall_q;
  logic [31:0] flush_cnt_q;

  // Stall counts cycles the head is held; flush counts flushes that actually discard something.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_q     <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (out_valid & ~out_ready)               stall_q     <= stall_q + 32'd1;
      if (flush & ((count_q != '0) | in_valid)) flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign stall_cycles = stall_q;
  assign flush_count  = flush_cnt_q;
`else
  // Counters are not built in the default configuration.
`endif

endmodule

// File: tb/tb_if_id_stage.sv
module tb_if_id_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [31:0] in_instr;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic [5:0]  opcode;
  logic [4:0]  rs, rt, rd, shamt;
  logic [5:0]  funct;
  logic [31:0] imm_sext;
  logic        is_rtype;
`ifdef IF_ID_PERF_CNT_EN
  logic [31:0] stall_cycles;
  logic [31:0] flush_count;
  logic [31:0] stall_base;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  if_id_stage #(.DEPTH(2), .PC_W(32), .INSTR_W(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pc     (in_pc),
    .in_instr  (in_instr),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pc    (out_pc),
    .out_instr (out_instr),
    .opcode    (opcode),
    .rs        (rs),
    .rt        (rt),
    .rd        (rd),
    .shamt     (shamt),
    .funct     (funct),
    .imm_sext  (imm_sext),
    .is_rtype  (is_rtype)
`ifdef IF_ID_PERF_CNT_EN
    ,
    .stall_cycles (stall_cycles),
    .flush_count  (flush_count)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle just after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] instr);
    in_valid = v;
    in_pc    = pc;
    in_instr = instr;
  endtask

  initial begin
    // Reset with arbitrary inputs toggling.
    reset = 1'b0;
    flush = 1'b0;
    out_ready = 1'b0;
    drive(1'b0, 32'd0, 32'd0);
    for (int i = 0; i < 4; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_pc     = $urandom;
      in_instr  = $urandom;
      out_ready = 1'($urandom_range(0, 1));
      step();
    end
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_pc",    out_pc,         32'd0);
    check("rst_out_instr", out_instr,      32'd0);
    check("rst_imm",       imm_sext,       32'd0);
    check("rst_is_rtype",  32'(is_rtype),  32'd0);
    drive(1'b0, 32'd0, 32'd0);
    out_ready = 1'b0;
    reset = 1'b1;
    #1;
    check("post_rst_in_ready", 32'(in_ready), 32'd1);

    // Streaming: second edge is a simultaneous push/pop at count 1.
    out_ready = 1'b1;
    drive(1'b1, 32'd0, 32'h00221820);
    step();
    check("s1_valid",  32'(out_valid), 32'd1);
    check("s1_pc",     out_pc,         32'd0);
    check("s1_opcode", 32'(opcode),    32'd0);
    check("s1_rs",     32'(rs),        32'd1);
    check("s1_rt",     32'(rt),        32'd2);
    check("s1_rd",     32'(rd),        32'd3);
    check("s1_shamt",  32'(shamt),     32'd0);
    check("s1_funct",  32'(funct),     32'h20);
    check("s1_rtype",  32'(is_rtype),  32'd1);
    drive(1'b1, 32'd1, 32'h2109000A);
    step();
    check("s2_valid",  32'(out_valid), 32'd1);
    check("s2_pc",     out_pc,         32'd1);
    check("s2_opcode", 32'(opcode),    32'h08);
    check("s2_rs",     32'(rs),        32'd8);
    check("s2_rt",     32'(rt),        32'd9);
    check("s2_imm",    imm_sext,       32'h0000000A);
    check("s2_rtype",  32'(is_rtype),  32'd0);
    check("s2_in_ready", 32'(in_ready), 32'd1);
    drive(1'b0, 32'd0, 32'd0);
    step();
    check("s3_empty",  32'(out_valid), 32'd0);
    check("s3_instr",  out_instr,      32'd0);

    // Backpressure: three offered, two accepted, drained in order.
    out_ready = 1'b0;
    drive(1'b1, 32'd0, 32'h11110000);
    step();
    check("bp1_in_ready", 32'(in_ready), 32'd1);
    drive(1'b1, 32'd1, 32'h11110001);
    step();
    check("bp2_in_ready", 32'(in_ready), 32'd0);
    drive(1'b1, 32'd2, 32'h11110002);
    step();
    step();
    check("bp3_in_ready", 32'(in_ready), 32'd0);
    check("bp3_head_pc",  out_pc,        32'd0);
    check("bp3_hold",     out_instr,     32'h11110000);
    out_ready = 1'b1;
    step();
    check("bp4_pc", out_pc, 32'd1);
    step();
    check("bp5_pc",    out_pc,    32'd2);
    check("bp5_instr", out_instr, 32'h11110002);
    drive(1'b0, 32'd0, 32'd0);
    step();
    check("bp6_empty", 32'(out_valid), 32'd0);

    // Sign extension of the immediate.
    drive(1'b1, 32'd5, 32'h2108FFFF);
    step();
    check("sx_neg", imm_sext, 32'hFFFFFFFF);
    drive(1'b1, 32'd6, 32'h21087FFF);
    step();
    check("sx_pos", imm_sext, 32'h00007FFF);
    drive(1'b0, 32'd0, 32'd0);
    step();

    // Flush with a full buffer and an incoming entry.
    out_ready = 1'b0;
    drive(1'b1, 32'd10, 32'hA0000010);
    step();
    drive(1'b1, 32'd11, 32'hA0000011);
    step();
    check("fl_full", 32'(in_ready), 32'd0);
    flush = 1'b1;
    drive(1'b1, 32'd99, 32'hA0000099);
    step();
    flush = 1'b0;
    drive(1'b0, 32'd0, 32'd0);
    check("fl_valid",    32'(out_valid), 32'd0);
    check("fl_in_ready", 32'(in_ready),  32'd1);
    step();
    check("fl_no_ghost", 32'(out_valid), 32'd0);

    // Flush with one entry and a push that would otherwise be accepted.
    drive(1'b1, 32'd12, 32'hA0000012);
    step();
    flush = 1'b1;
    drive(1'b1, 32'd13, 32'hA0000013);
    step();
    flush = 1'b0;
    drive(1'b0, 32'd0, 32'd0);
    step();
    check("fl2_valid", 32'(out_valid), 32'd0);
    drive(1'b1, 32'd20, 32'hA0000020);
    step();
    drive(1'b0, 32'd0, 32'd0);
    check("fl2_after_pc", out_pc, 32'd20);

`ifdef IF_ID_PERF_CNT_EN
    stall_base = stall_cycles;
    step();
    step();
    step();
    check("perf_stall3", stall_cycles - stall_base, 32'd3);
    check("perf_flushes", flush_count, 32'd2);
`endif

    // Asynchronous reset mid-operation clears the head immediately.
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("arst_valid", 32'(out_valid), 32'd0);
    check("arst_pc",    out_pc,         32'd0);
    @(negedge clk);
    reset = 1'b1;
    out_ready = 1'b1;
    step();
    check("arst_stays_empty", 32'(out_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
